boot_sequencer: RTL

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - core power-up sequencer: clock gate, reset hold, first fetch, watchdog, orderly drain
module boot_sequencer #(
    parameter int ADDR_W        = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int RESET_CYCLES  = 10,
    parameter int WDOG_CYCLES   = 25,
    parameter int DRAIN_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic              kick,
    input  logic              halt_req,
    output logic              cg_enable,
    output logic              core_rstn,
    output logic [ADDR_W-1:0] first_fetch_addr,
    output logic              first_fetch_trigger,
    output logic              wdog_expired,
    output logic [2:0]        state,
    output logic              busy
);

    // One counter serves every timed state, so it is sized for the longest phase.
    localparam int MAX_AB = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int MAX_CD = (WDOG_CYCLES > DRAIN_CYCLES) ? WDOG_CYCLES : DRAIN_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLK_ON   = 3'd1,
        S_RST_HOLD = 3'd2,
        S_FETCH    = 3'd3,
        S_RUN      = 3'd4,
        S_DRAIN    = 3'd5,
        S_HALTED   = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               expire;

    // A new boot is only taken from a quiescent state.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_FAULT));
    // A kick in the same cycle as the terminal count wins over the fault.
    assign expire = (state_q == S_RUN) && !kick && (cnt_q == WDOG_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED, S_FAULT: begin
                if (accept) state_d = S_CLK_ON;
            end
            S_CLK_ON: begin
                if (cnt_q == SETTLE_LAST) state_d = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                if (cnt_q == RESET_LAST) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (expire) begin
                    state_d = S_FAULT;
                end else if (halt_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) state_d = S_HALTED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded purely from the state register.
    always_comb begin
        cg_enable           = 1'b0;
        core_rstn           = 1'b0;
        first_fetch_trigger = 1'b0;
        busy                = 1'b0;
        case (state_q)
            S_CLK_ON, S_RST_HOLD: begin
                cg_enable = 1'b1;
                busy      = 1'b1;
            end
            S_FETCH: begin
                cg_enable           = 1'b1;
                core_rstn           = 1'b1;
                first_fetch_trigger = 1'b1;
                busy                = 1'b1;
            end
            S_RUN, S_DRAIN: begin
                cg_enable = 1'b1;
                core_rstn = 1'b1;
                busy      = 1'b1;
            end
            S_HALTED: begin
                core_rstn = 1'b1;
            end
            default: begin
                cg_enable = 1'b0;
            end
        endcase
    end

    // Shared phase/watchdog counter: restarts on every transition and on a kick in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if ((state_q == S_RUN) && kick) begin
            cnt_q <= '0;
        end else if ((state_q == S_CLK_ON) || (state_q == S_RST_HOLD) ||
                     (state_q == S_RUN) || (state_q == S_DRAIN)) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Fetch address capture and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_fetch_addr <= '0;
            wdog_expired     <= 1'b0;
        end else if (accept) begin
            first_fetch_addr <= boot_addr;
            wdog_expired     <= 1'b0;
        end else if (expire) begin
            wdog_expired     <= 1'b1;
        end
    end

    assign state = state_q;

endmodule
